// File: rtl/model_fnn_output_projection_pkg.sv
// Shared types and defaults for the FNN output projection stage.
package model_fnn_pkg;

  localparam int DATA_SIZE_DEFAULT = 64;
  localparam int L_MAX_DEFAULT     = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_H = 2'd1,
    MAC    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/model_fnn_output_projection_if.sv
// Stream/handshake bundle between the projection stage and its neighbours.
interface model_fnn_output_projection_if
  import model_fnn_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
);

  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_Y_IN;
  logic [DATA_SIZE-1:0] SIZE_L_IN;
  logic                 H_IN_ENABLE;
  logic [DATA_SIZE-1:0] H_IN;
  logic                 P_IN_ENABLE;
  logic [DATA_SIZE-1:0] P_IN;
  logic                 Y_OUT_ENABLE;
  logic [DATA_SIZE-1:0] Y_OUT;
  logic [DATA_SIZE-1:0] Y_OUT_INDEX;

  modport master (
    output START, SIZE_Y_IN, SIZE_L_IN, H_IN_ENABLE, H_IN, P_IN_ENABLE, P_IN,
    input  READY, Y_OUT_ENABLE, Y_OUT, Y_OUT_INDEX
  );

  modport slave (
    input  START, SIZE_Y_IN, SIZE_L_IN, H_IN_ENABLE, H_IN, P_IN_ENABLE, P_IN,
    output READY, Y_OUT_ENABLE, Y_OUT, Y_OUT_INDEX
  );

endinterface

// File: rtl/model_fnn_output_projection_mac.sv
// Combinational multiply-accumulate; product and sum wrap to DATA_SIZE bits.
module model_fnn_mac
  import model_fnn_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic [DATA_SIZE-1:0] acc,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic [DATA_SIZE-1:0] sum
);

  assign sum = acc + a * b;

endmodule

// File: rtl/model_fnn_output_projection.sv
// Buffers streamed h, then projects it with row-major P into a strobed y stream.
module model_fnn_output_projection
  import model_fnn_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEFAULT,
  parameter int CONTROL_SIZE = 4,
  parameter int L_MAX        = L_MAX_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RST,
  model_fnn_output_projection_if.slave  bus
);

  localparam int AW = addr_width(L_MAX);

  if (L_MAX < 2 || CONTROL_SIZE < 1) begin : g_param_check
    $error("model_fnn_output_projection: L_MAX must be >= 2 and CONTROL_SIZE >= 1");
  end

  state_t               state_reg;
  logic [DATA_SIZE-1:0] ly_reg;
  logic [DATA_SIZE-1:0] ll_reg;
  logic [DATA_SIZE-1:0] l_cnt_reg;
  logic [DATA_SIZE-1:0] j_cnt_reg;
  logic [DATA_SIZE-1:0] acc_reg;
  logic [DATA_SIZE-1:0] y_out_reg;
  logic [DATA_SIZE-1:0] y_index_reg;
  logic                 y_en_reg;
  logic                 ready_reg;

  logic [DATA_SIZE-1:0] h_mem [L_MAX];
  logic [AW-1:0]        h_addr;
  logic [DATA_SIZE-1:0] h_rd;
  logic [DATA_SIZE-1:0] sum;
  logic [DATA_SIZE-1:0] ll_next;
  logic                 h_we;

  assign h_addr  = l_cnt_reg[AW-1:0];
  assign h_rd    = h_mem[h_addr];
  assign h_we    = (state_reg == LOAD_H) && bus.H_IN_ENABLE;
  assign ll_next = (bus.SIZE_L_IN > DATA_SIZE'(L_MAX)) ? DATA_SIZE'(L_MAX) : bus.SIZE_L_IN;

  // h buffer contents are don't-care after reset, so entries carry no reset.
  for (genvar gi = 0; gi < L_MAX; gi++) begin : g_h_buf
    always_ff @(posedge CLK) begin
      if (h_we && (h_addr == AW'(gi))) begin
        h_mem[gi] <= bus.H_IN;
      end
    end
  end

  model_fnn_mac #(.DATA_SIZE(DATA_SIZE)) u_mac (
    .acc (acc_reg),
    .a   (bus.P_IN),
    .b   (h_rd),
    .sum (sum)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= IDLE;
      ly_reg      <= '0;
      ll_reg      <= '0;
      l_cnt_reg   <= '0;
      j_cnt_reg   <= '0;
      acc_reg     <= '0;
      y_out_reg   <= '0;
      y_index_reg <= '0;
      y_en_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      y_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.START) begin
            ly_reg    <= bus.SIZE_Y_IN;
            ll_reg    <= ll_next;
            l_cnt_reg <= '0;
            j_cnt_reg <= '0;
            acc_reg   <= '0;
            state_reg <= (bus.SIZE_Y_IN == '0 || ll_next == '0) ? DONE : LOAD_H;
          end
        end
        LOAD_H: begin
          if (bus.H_IN_ENABLE) begin
            if (l_cnt_reg == ll_reg - 1'b1) begin
              state_reg <= MAC;
              l_cnt_reg <= '0;
              j_cnt_reg <= '0;
              acc_reg   <= '0;
            end else begin
              l_cnt_reg <= l_cnt_reg + 1'b1;
            end
          end
        end
        MAC: begin
          if (bus.P_IN_ENABLE) begin
            if (l_cnt_reg == ll_reg - 1'b1) begin
              y_out_reg   <= sum;
              y_index_reg <= j_cnt_reg;
              y_en_reg    <= 1'b1;
              acc_reg     <= '0;
              l_cnt_reg   <= '0;
              j_cnt_reg   <= j_cnt_reg + 1'b1;
              // Final element: READY rises together with its strobe.
              if (j_cnt_reg == ly_reg - 1'b1) begin
                state_reg <= DONE;
                ready_reg <= 1'b1;
              end
            end else begin
              acc_reg   <= sum;
              l_cnt_reg <= l_cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          // Zero-size jobs arrive with READY low and pulse it one cycle later.
          if (ready_reg) begin
            ready_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.READY        = ready_reg;
  assign bus.Y_OUT_ENABLE = y_en_reg;
  assign bus.Y_OUT        = y_out_reg;
  assign bus.Y_OUT_INDEX  = y_index_reg;

endmodule

// File: tb/tb_model_fnn_output_projection.sv
// Scoreboard bench for model_fnn_output_projection (instantiated with L_MAX=4).
module tb_model_fnn_output_projection;

  localparam int DW    = 64;
  localparam int L_MAX = 4;

  typedef struct packed {
    logic [DW-1:0] idx;
    logic [DW-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  model_fnn_output_projection_if #(.DATA_SIZE(DW)) bus ();

  model_fnn_output_projection #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (4),
    .L_MAX        (L_MAX)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int      n_compared   = 0;
  int      n_mismatched = 0;
  int      ready_count  = 0;
  logic    job_expect_y = 1'b0;
  logic    prev_y_en    = 1'b0;
  exp_t    sb[$];
  logic [DW-1:0] h_arr [8];
  logic [DW-1:0] p_arr [16];

  task automatic check_value(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Output monitor: pops the scoreboard on every y strobe.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.Y_OUT_ENABLE) begin
        check_value("y_enable_single", {63'd0, prev_y_en}, 64'd0);
        if (sb.size() == 0) begin
          check_value("unexpected_y_strobe", bus.Y_OUT_INDEX, ~bus.Y_OUT_INDEX);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("y[%0d] = %0d (expected %0d)", bus.Y_OUT_INDEX, $signed(bus.Y_OUT), $signed(e.val));
          check_value("y_index", bus.Y_OUT_INDEX, e.idx);
          check_value("y_value", bus.Y_OUT, e.val);
        end
      end
      if (bus.READY) begin
        ready_count++;
        check_value("ready_with_last_y", {63'd0, bus.Y_OUT_ENABLE}, {63'd0, job_expect_y});
        check_value("queue_empty_at_ready", 64'(sb.size()), 64'd0);
      end
    end
    prev_y_en <= bus.Y_OUT_ENABLE;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp_l(input int sl);
    return (sl > L_MAX) ? L_MAX : sl;
  endfunction

  // Reference dot products, 64-bit wrap-around.
  task automatic push_expected(input int sy, input int sl);
    int ll;
    logic [DW-1:0] acc;
    ll = clamp_l(sl);
    job_expect_y = (sy != 0) && (ll != 0);
    if (!job_expect_y) return;
    for (int j = 0; j < sy; j++) begin
      acc = '0;
      for (int l = 0; l < ll; l++) acc = acc + p_arr[j*ll + l] * h_arr[l];
      sb.push_back('{idx: 64'(j), val: acc});
    end
  endtask

  task automatic start_job(input int sy, input int sl);
    @(negedge clk);
    bus.START     = 1'b1;
    bus.SIZE_Y_IN = 64'(sy);
    bus.SIZE_L_IN = 64'(sl);
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic load_h(input int n, input bit noise);
    for (int l = 0; l < n; l++) begin
      bus.H_IN_ENABLE = 1'b1;
      bus.H_IN        = h_arr[l];
      if (noise) begin
        bus.P_IN_ENABLE = 1'b1;
        bus.P_IN        = 64'(32'hdead_0000 + l);
      end
      @(negedge clk);
      bus.H_IN_ENABLE = 1'b0;
      bus.P_IN_ENABLE = 1'b0;
    end
  endtask

  task automatic send_p(input logic [DW-1:0] v, input int gap, input bit noise);
    for (int g = 0; g < gap; g++) begin
      if (noise) begin
        bus.H_IN_ENABLE = 1'b1;
        bus.H_IN        = 64'd777;
        bus.START       = (g == 0);
        bus.SIZE_Y_IN   = 64'd3;
        bus.SIZE_L_IN   = 64'd1;
      end
      @(negedge clk);
      bus.H_IN_ENABLE = 1'b0;
      bus.START       = 1'b0;
    end
    bus.P_IN_ENABLE = 1'b1;
    bus.P_IN        = v;
    @(negedge clk);
    bus.P_IN_ENABLE = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int start_cnt;
    start_cnt = ready_count;
    for (int i = 0; i < budget && ready_count == start_cnt; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_value(tag, 64'(ready_count - start_cnt), 64'd1);
    check_value({tag, "_queue"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_job(input string tag, input int sy, input int sl,
                         input int gap_max, input bit noise);
    int ll;
    ll = clamp_l(sl);
    push_expected(sy, sl);
    start_job(sy, sl);
    if (sy != 0 && ll != 0) begin
      load_h(ll, noise);
      for (int k = 0; k < sy * ll; k++) begin
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        if (noise && k == 1 && gap == 0) gap = 1;
        send_p(p_arr[k], gap, noise);
      end
    end
    wait_ready(tag, 40);
  endtask

  initial begin
    bus.START       = 1'b0;
    bus.SIZE_Y_IN   = '0;
    bus.SIZE_L_IN   = '0;
    bus.H_IN_ENABLE = 1'b0;
    bus.H_IN        = '0;
    bus.P_IN_ENABLE = 1'b0;
    bus.P_IN        = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset_ready", {63'd0, bus.READY}, 64'd0);
    check_value("reset_y_en", {63'd0, bus.Y_OUT_ENABLE}, 64'd0);
    check_value("reset_y_out", bus.Y_OUT, 64'd0);
    check_value("reset_y_index", bus.Y_OUT_INDEX, 64'd0);
    rst = 1'b1;

    // T1: reset in the middle of the second row aborts the job
    h_arr[0] = 64'd1; h_arr[1] = 64'd2; h_arr[2] = 64'd3;
    p_arr[0] = 64'd1; p_arr[1] = 64'd0; p_arr[2] = 64'd0;
    p_arr[3] = 64'd1; p_arr[4] = 64'd1; p_arr[5] = 64'd1;
    push_expected(2, 3);
    start_job(2, 3);
    load_h(3, 1'b0);
    for (int k = 0; k < 5; k++) send_p(p_arr[k], 0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_value("t1_rst_ready", {63'd0, bus.READY}, 64'd0);
    check_value("t1_rst_y_en", {63'd0, bus.Y_OUT_ENABLE}, 64'd0);
    check_value("t1_rst_y_out", bus.Y_OUT, 64'd0);
    check_value("t1_rst_y_index", bus.Y_OUT_INDEX, 64'd0);
    sb.delete();
    begin
      int rc;
      rc = ready_count;
      rst = 1'b1;
      bus.P_IN_ENABLE = 1'b1; bus.P_IN = 64'd9;
      bus.H_IN_ENABLE = 1'b1; bus.H_IN = 64'd9;
      @(negedge clk);
      bus.P_IN_ENABLE = 1'b0;
      bus.H_IN_ENABLE = 1'b0;
      repeat (4) @(negedge clk);
      check_value("t1_no_ready_after_abort", 64'(ready_count - rc), 64'd0);
    end

    // T2: basic projection, back-to-back P strobes
    run_job("t2_basic", 2, 3, 0, 1'b0);

    // T3: negative values and multiplication wrap
    h_arr[0] = -64'sd3; h_arr[1] = 64'h4000_0000_0000_0000;
    p_arr[0] = 64'd5;   p_arr[1] = 64'd4;
    run_job("t3_wrap", 1, 2, 0, 1'b0);

    // T4: zero-size jobs; READY exactly two cycles after START
    push_expected(0, 3);
    start_job(0, 3);
    check_value("t4_ready_cycle1", {63'd0, bus.READY}, 64'd0);
    @(negedge clk);
    check_value("t4_ready_cycle2", {63'd0, bus.READY}, 64'd1);
    @(negedge clk);
    check_value("t4_ready_cycle3", {63'd0, bus.READY}, 64'd0);
    run_job("t4_zero_l", 2, 0, 0, 1'b0);

    // T5: random gaps, ignored strobes, START during MAC
    h_arr[0] = 64'd1; h_arr[1] = 64'd2; h_arr[2] = 64'd3;
    p_arr[0] = 64'd1; p_arr[1] = 64'd0; p_arr[2] = 64'd0;
    p_arr[3] = 64'd1; p_arr[4] = 64'd1; p_arr[5] = 64'd1;
    for (int r = 0; r < 3; r++) run_job("t5_gapped", 2, 3, 3, 1'b1);

    // Extra: three rows of random weights and h
    for (int l = 0; l < 4; l++) h_arr[l] = {$urandom(), $urandom()};
    for (int k = 0; k < 12; k++) p_arr[k] = {$urandom(), $urandom()};
    run_job("rand_3x4", 3, 4, 2, 1'b0);

    // T6: SIZE_L_IN clamped to L_MAX
    for (int l = 0; l < 4; l++) begin
      h_arr[l] = 64'd1;
      p_arr[l] = 64'd2;
    end
    run_job("t6_clamp", 1, 9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
